ysyx_25020037_axi_sram: RTL and testbench

AXI4 responder (slave) that backs a word-addressed on-chip SRAM model and answers the core's load/store unit and any other AXI4 initiator on the data bus. Read and write channels run independent state machines with programmable response latency. Single- and multi-beat FIXED/INCR bursts are supported, with byte-strobed writes and SLVERR on out-of-range or unsupported requests. Only one outstanding transaction per direction is handled.

---
 rtl/ysyx_25020037_axi_sram.sv | 222 ++++++++++++++++++++++
 tb/tb_ysyx_25020037_axi_sram.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25020037_axi_sram.sv
// AXI4 responder backed by a word-addressed on-chip SRAM.
// Independent read/write FSMs, FIXED/INCR bursts, byte strobes, SLVERR on bad requests.
module ysyx_25020037_axi_sram #(
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
    parameter int          AW         = 10,
    parameter int          RD_LATENCY = 2,
    parameter int          WR_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] awaddr,
    input  logic [3:0]  awid,
    input  logic [7:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic        wvalid,
    output logic        wready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    output logic        bvalid,
    input  logic        bready,
    output logic [1:0]  bresp,
    output logic [3:0]  bid,
    input  logic        arvalid,
    output logic        arready,
    input  logic [31:0] araddr,
    input  logic [3:0]  arid,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    output logic        rvalid,
    input  logic        rready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic [3:0]  rid
);
    localparam int          OW        = AW + 2;
    localparam int          DEPTH     = 1 << AW;
    localparam logic [32:0] MEM_BYTES = 33'(DEPTH) << 2;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_LAT, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_LAT, R_DATA} r_state_t;

    localparam w_state_t W_AFTER = (WR_LATENCY == 0) ? W_RESP : W_LAT;
    localparam r_state_t R_AFTER = (RD_LATENCY == 0) ? R_DATA : R_LAT;

    function automatic logic [OW-1:0] step_of(input logic [1:0] burst, input logic [2:0] size);
        step_of = (burst == 2'b01) ? (OW'(1) << size) : '0;
    endfunction

    // Range is judged on the start address only; the burst then wraps inside the array.
    function automatic logic bad_req(input logic [31:0] addr, input logic [1:0] burst,
                                     input logic [2:0] size);
        logic [31:0] off;
        off     = addr - BASE_ADDR;
        bad_req = ({1'b0, off} >= MEM_BYTES) || burst[1] || (size > 3'd2);
    endfunction

    logic [31:0] mem [DEPTH];

    w_state_t      w_state, w_next;
    logic [OW-1:0] w_off, w_step, aw_off;
    logic [7:0]    w_len, w_beat;
    logic [3:0]    w_id, w_lat;
    logic          w_bad, w_lasterr, aw_bad;
    logic          aw_accept, w_fire, w_final, w_done, mem_we;
    logic [AW-1:0] mem_idx;

    r_state_t      r_state, r_next;
    logic [OW-1:0] r_off, r_step, ar_off, rd_off;
    logic [7:0]    r_len, r_beat;
    logic [3:0]    r_id, r_lat;
    logic          r_bad, ar_bad, ar_accept, r_fire, r_final, rd_load, rd_bad;
    logic [31:0]   rd_word, rdata_q;

    assign aw_off    = OW'(awaddr - BASE_ADDR);
    assign aw_bad    = bad_req(awaddr, awburst, awsize);
    assign aw_accept = (w_state == W_IDLE) && awvalid && wvalid && !rst;
    assign w_fire    = (w_state == W_DATA) && wvalid;
    assign w_final   = (w_beat == w_len);
    assign w_done    = w_fire && (wlast || w_final);

    assign awready = aw_accept;
    assign wready  = aw_accept || (w_state == W_DATA);
    assign bvalid  = (w_state == W_RESP);
    assign bresp   = (bvalid && (w_bad || w_lasterr)) ? 2'b10 : 2'b00;
    assign bid     = bvalid ? w_id : 4'd0;

    assign mem_we  = (aw_accept && !aw_bad) || (w_fire && !w_bad);
    assign mem_idx = aw_accept ? aw_off[OW-1:2] : w_off[OW-1:2];

    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE: if (aw_accept) w_next = (awlen == 8'd0) ? W_AFTER : W_DATA;
            W_DATA: if (w_done) w_next = W_AFTER;
            W_LAT:  if (w_lat == 4'd0) w_next = W_RESP;
            W_RESP: if (bready) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state   <= W_IDLE;
            w_off     <= '0;
            w_step    <= '0;
            w_len     <= '0;
            w_beat    <= '0;
            w_id      <= '0;
            w_bad     <= 1'b0;
            w_lasterr <= 1'b0;
            w_lat     <= '0;
        end else begin
            w_state <= w_next;
            w_lat   <= (w_state == W_LAT) ? w_lat - 4'd1 : 4'(WR_LATENCY - 1);
            if (aw_accept) begin
                w_off     <= aw_off + step_of(awburst, awsize);
                w_step    <= step_of(awburst, awsize);
                w_len     <= awlen;
                w_beat    <= 8'd1;
                w_id      <= awid;
                w_bad     <= aw_bad;
                w_lasterr <= (wlast != (awlen == 8'd0));
            end else if (w_fire) begin
                w_off  <= w_off + w_step;
                w_beat <= w_beat + 8'd1;
                if (wlast != w_final) w_lasterr <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we)
            for (int i = 0; i < 4; i++)
                if (wstrb[i]) mem[mem_idx][8*i +: 8] <= wdata[8*i +: 8];
    end

    assign ar_off    = OW'(araddr - BASE_ADDR);
    assign ar_bad    = bad_req(araddr, arburst, arsize);
    assign ar_accept = (r_state == R_IDLE) && arvalid && !rst;
    assign r_fire    = (r_state == R_DATA) && rready;
    assign r_final   = (r_beat == r_len);

    assign arready = (r_state == R_IDLE) && !rst;
    assign rvalid  = (r_state == R_DATA);
    assign rlast   = rvalid && r_final;
    assign rid     = rvalid ? r_id : 4'd0;
    assign rresp   = (rvalid && r_bad) ? 2'b10 : 2'b00;
    assign rdata   = rdata_q;

    // rdata is registered so it stays put while stalled; picks the word for the next beat.
    always_comb begin
        rd_load = 1'b0;
        rd_off  = r_off;
        rd_bad  = r_bad;
        case (r_state)
            R_IDLE: if (ar_accept && RD_LATENCY == 0) begin
                rd_load = 1'b1;
                rd_off  = ar_off;
                rd_bad  = ar_bad;
            end
            R_LAT:  if (r_lat == 4'd0) rd_load = 1'b1;
            R_DATA: if (r_fire && !r_final) begin
                rd_load = 1'b1;
                rd_off  = r_off + r_step;
            end
            default: rd_load = 1'b0;
        endcase
    end

    // A write landing on the same edge is merged so the next presented beat sees it.
    always_comb begin
        rd_word = mem[rd_off[OW-1:2]];
        if (mem_we && (mem_idx == rd_off[OW-1:2]))
            for (int i = 0; i < 4; i++)
                if (wstrb[i]) rd_word[8*i +: 8] = wdata[8*i +: 8];
    end

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE: if (ar_accept) r_next = R_AFTER;
            R_LAT:  if (r_lat == 4'd0) r_next = R_DATA;
            R_DATA: if (r_fire && r_final) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= R_IDLE;
            r_off   <= '0;
            r_step  <= '0;
            r_len   <= '0;
            r_beat  <= '0;
            r_id    <= '0;
            r_bad   <= 1'b0;
            r_lat   <= '0;
            rdata_q <= '0;
        end else begin
            r_state <= r_next;
            r_lat   <= (r_state == R_LAT) ? r_lat - 4'd1 : 4'(RD_LATENCY - 1);
            if (ar_accept) begin
                r_off  <= ar_off;
                r_step <= step_of(arburst, arsize);
                r_len  <= arlen;
                r_beat <= 8'd0;
                r_id   <= arid;
                r_bad  <= ar_bad;
            end else if (r_fire && !r_final) begin
                r_off  <= r_off + r_step;
                r_beat <= r_beat + 8'd1;
            end
            if (rd_load) rdata_q <= rd_bad ? 32'd0 : rd_word;
        end
    end
endmodule

// File: tb/tb_ysyx_25020037_axi_sram.sv
// Directed bench for ysyx_25020037_axi_sram with default parameters (RD_LATENCY=2, WR_LATENCY=1).
module tb_ysyx_25020037_axi_sram;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic        arvalid, arready, rvalid, rready, rlast;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [3:0]  awid, wstrb, bid, arid, rid;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, bresp, arburst, rresp;

    int checks = 0;
    int errors = 0;

    logic [31:0] wr_data [4];
    logic [3:0]  wr_strb [4];
    logic [1:0]  wr_bresp;
    logic [3:0]  wr_bid;
    int          wr_lat;

    logic [31:0] rd_data [4];
    logic        rd_last [4];
    logic [1:0]  rd_resp;
    logic [3:0]  rd_id;
    int          rd_lat;
    logic [31:0] rd_stall_data;
    logic        rd_stall_valid;
    logic        saw_rvalid;

    ysyx_25020037_axi_sram dut (
        .clk(clk), .rst(rst),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid),
        .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
        .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .rlast(rlast), .rid(rid)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Entered and left at #1 after a rising edge; latency counts the handshake cycle as 0.
    task automatic applyWrite(input logic [31:0] addr, input logic [3:0] id,
                              input logic [7:0] len, input logic [1:0] burst);
        int n;
        awaddr = addr; awid = id; awlen = len; awsize = 3'd2; awburst = burst;
        awvalid = 1'b1; bready = 1'b1;
        for (int b = 0; b <= int'(len); b++) begin
            wvalid = 1'b1; wdata = wr_data[b]; wstrb = wr_strb[b]; wlast = (b == int'(len));
            n = 0;
            @(negedge clk);
            while (!wready && n < 50) begin @(negedge clk); n++; end
            if (!wready) begin
                checkOutput("w_handshake_timeout", 32'd0, 32'd1);
                awvalid = 1'b0; wvalid = 1'b0;
                return;
            end
            @(posedge clk); #1;
            awvalid = 1'b0;
        end
        wvalid = 1'b0; wlast = 1'b0;
        n = 1;
        @(negedge clk);
        while (!bvalid && n < 50) begin @(negedge clk); n++; end
        if (!bvalid) begin
            checkOutput("b_timeout", 32'd0, 32'd1);
            wr_lat = -1;
            return;
        end
        wr_lat = n; wr_bresp = bresp; wr_bid = bid;
        @(posedge clk); #1;
        bready = 1'b0;
    endtask

    task automatic applyRead(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                             input logic [1:0] burst, input int stall_beat);
        int n;
        araddr = addr; arid = id; arlen = len; arsize = 3'd2; arburst = burst;
        arvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!arready && n < 50) begin @(negedge clk); n++; end
        if (!arready) begin
            checkOutput("ar_timeout", 32'd0, 32'd1);
            arvalid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        arvalid = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            rready = (b != stall_beat);
            n = 1;
            @(negedge clk);
            while (!rvalid && n < 50) begin @(negedge clk); n++; end
            if (!rvalid) begin
                checkOutput("r_timeout", 32'd0, 32'd1);
                rready = 1'b1;
                return;
            end
            if (b == 0) rd_lat = n;
            if (b == stall_beat) begin
                rd_stall_data = rdata;
                @(posedge clk); #1;
                rready = 1'b1;
                @(negedge clk);
                rd_stall_valid = rvalid;
            end
            rd_data[b] = rdata; rd_last[b] = rlast; rd_resp = rresp; rd_id = rid;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        awvalid = 0; awaddr = 0; awid = 0; awlen = 0; awsize = 0; awburst = 0;
        wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 0;
        arvalid = 0; araddr = 0; arid = 0; arlen = 0; arsize = 0; arburst = 0; rready = 1;
        for (int i = 0; i < 4; i++) begin wr_data[i] = 0; wr_strb[i] = 4'hF; end

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_ready", {29'd0, awready, wready, arready}, 32'd0);
        checkOutput("rst_valid", {29'd0, bvalid, rvalid, rlast}, 32'd0);
        checkOutput("rst_resp_id", {20'd0, bresp, rresp, bid, rid}, 32'd0);
        checkOutput("rst_rdata", rdata, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("arready_after_rst", {31'd0, arready}, 32'd1);
        @(posedge clk); #1;

        wr_data[0] = 32'hDEADBEEF; wr_strb[0] = 4'hF;
        applyWrite(32'h8000_0004, 4'd1, 8'd0, 2'b01);
        checkOutput("single_w_bresp", {30'd0, wr_bresp}, 32'd0);
        checkOutput("single_w_bid", {28'd0, wr_bid}, 32'd1);
        checkOutput("single_w_lat", wr_lat, 32'd2);
        applyRead(32'h8000_0004, 4'd6, 8'd0, 2'b01, -1);
        checkOutput("single_r_data", rd_data[0], 32'hDEADBEEF);
        checkOutput("single_r_last", {31'd0, rd_last[0]}, 32'd1);
        checkOutput("single_r_lat", rd_lat, 32'd3);
        checkOutput("single_r_resp_id", {26'd0, rd_resp, rd_id}, {26'd0, 2'b00, 4'd6});

        wr_data[0] = 32'h11223344; wr_strb[0] = 4'hF;
        applyWrite(32'h8000_0008, 4'd0, 8'd0, 2'b01);
        wr_data[0] = 32'h0000AA00; wr_strb[0] = 4'b0010;
        applyWrite(32'h8000_0008, 4'd0, 8'd0, 2'b01);
        applyRead(32'h8000_0008, 4'd0, 8'd0, 2'b01, -1);
        checkOutput("strobe_data", rd_data[0], 32'h1122AA44);

        for (int i = 0; i < 4; i++) begin wr_data[i] = i + 1; wr_strb[i] = 4'hF; end
        applyWrite(32'h8000_0010, 4'd2, 8'd3, 2'b01);
        checkOutput("burst_w_bresp", {30'd0, wr_bresp}, 32'd0);
        applyRead(32'h8000_0010, 4'd4, 8'd3, 2'b01, 1);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("burst_r_data%0d", i), rd_data[i], i + 1);
            checkOutput($sformatf("burst_r_last%0d", i), {31'd0, rd_last[i]}, (i == 3) ? 32'd1 : 32'd0);
        end
        checkOutput("burst_stall_data", rd_stall_data, 32'd2);
        checkOutput("burst_stall_valid", {31'd0, rd_stall_valid}, 32'd1);

        wr_data[0] = 32'h0000000A; wr_data[1] = 32'h0000000B;
        applyWrite(32'h8000_0030, 4'd0, 8'd1, 2'b00);
        applyRead(32'h8000_0030, 4'd0, 8'd0, 2'b01, -1);
        checkOutput("fixed_w_data", rd_data[0], 32'h0000000B);

        applyRead(32'h7FFF_FFFC, 4'd7, 8'd0, 2'b01, -1);
        checkOutput("oor_r_resp", {30'd0, rd_resp}, 32'd2);
        checkOutput("oor_r_data", rd_data[0], 32'd0);

        wr_data[0] = 32'h12345678; wr_strb[0] = 4'hF;
        applyWrite(32'h8000_0004, 4'd0, 8'd0, 2'b10);
        checkOutput("badburst_bresp", {30'd0, wr_bresp}, 32'd2);
        applyRead(32'h8000_0004, 4'd0, 8'd0, 2'b01, -1);
        checkOutput("badburst_mem", rd_data[0], 32'hDEADBEEF);

        araddr = 32'h8000_0010; arid = 4'd2; arlen = 8'd1; arsize = 3'd2; arburst = 2'b01;
        arvalid = 1'b1; rready = 1'b1;
        @(posedge clk); #1 arvalid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst_mid_rvalid", {31'd0, rvalid}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_mid_arready", {31'd0, arready}, 32'd1);
        saw_rvalid = rvalid;
        for (int i = 0; i < 4; i++) begin @(negedge clk); saw_rvalid = saw_rvalid | rvalid; end
        checkOutput("rst_mid_no_rvalid", {31'd0, saw_rvalid}, 32'd0);
        @(posedge clk); #1;
        applyRead(32'h8000_0014, 4'd0, 8'd0, 2'b01, -1);
        checkOutput("after_rst_read", rd_data[0], 32'd2);

        wr_data[0] = 32'hCAFEF00D; wr_strb[0] = 4'hF;
        fork
            applyWrite(32'h8000_0020, 4'd3, 8'd0, 2'b01);
            applyRead(32'h8000_0010, 4'd5, 8'd0, 2'b01, -1);
        join
        checkOutput("conc_bid", {28'd0, wr_bid}, 32'd3);
        checkOutput("conc_rid", {28'd0, rd_id}, 32'd5);
        checkOutput("conc_w_lat", wr_lat, 32'd2);
        checkOutput("conc_r_lat", rd_lat, 32'd3);
        checkOutput("conc_r_data", rd_data[0], 32'd1);
        applyRead(32'h8000_0020, 4'd0, 8'd0, 2'b01, -1);
        checkOutput("conc_w_mem", rd_data[0], 32'hCAFEF00D);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
